// File: rtl/ram_stream_reader.sv
// ram_stream_reader: walks a contiguous RAM address range on start, absorbs the
// RAM read latency and streams the returned words out in address order.
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_start             one-cycle job strobe, honoured only when idle
//   i_base_addr         first address of the job
//   i_num_words         word count 0..2^ADDR_WIDTH
//   o_busy, o_done      job in progress / one-cycle completion pulse
//   o_read_req/addr     RAM read port request and address
//   i_read_data         RAM read data, valid LAT cycles after the request
//   o_m_valid/data      output stream, i_m_ready is the downstream accept
module ram_stream_reader #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 12,
  parameter int OUTPUT_REG = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_num_words,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_read_req,
  output logic [ADDR_WIDTH-1:0] o_read_addr,
  input  logic [DATA_WIDTH-1:0] i_read_data,
  output logic                  o_m_valid,
  output logic [DATA_WIDTH-1:0] o_m_data,
  input  logic                  i_m_ready
);
  localparam int LAT = 1 + OUTPUT_REG;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + LAT) + 1;
  localparam logic [ADDR_WIDTH:0] ONE = 1;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_rem;
  logic [LAT-1:0]        r_pipe;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_count, w_inflight;
  logic                  w_req, w_push, w_pop, w_drained;
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LAT; i++) w_inflight = w_inflight + CW'(r_pipe[i]);
  end
  // Credit uses the registered count only, so a same-cycle pop never lets the
  // FIFO plus in-flight reads exceed its depth.
  assign w_req = (r_state == ISSUE) && (r_rem != '0) && ((r_count + w_inflight) < CW'(FIFO_DEPTH));
  assign w_push = r_pipe[LAT-1];
  assign w_pop = (r_count != '0) && i_m_ready;
  // Leaving DRAIN on the final pop puts done in the cycle right after it.
  assign w_drained = (w_inflight == '0) && (r_count == CW'(w_pop));
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_pipe  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_pipe[0] <= w_req;
      for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      if (w_req) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
        r_rem  <= r_rem - ONE;
      end
      case (r_state)
        IDLE:
          if (i_start) begin
            r_addr  <= i_base_addr;
            r_rem   <= i_num_words;
            r_state <= (i_num_words == '0) ? DONE : ISSUE;
          end
        ISSUE: if (w_req && r_rem == ONE) r_state <= DRAIN;
        DRAIN: if (w_drained) r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_read_data;
  end
  assign o_busy = (r_state == ISSUE) || (r_state == DRAIN);
  assign o_done = (r_state == DONE);
  assign o_read_req = w_req;
  assign o_read_addr = r_addr;
  assign o_m_valid = (r_count != '0);
  assign o_m_data = o_m_valid ? r_mem[r_rptr] : '0;
endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Read-side sequencer placed directly in front of the `ram` block's read port. On a start command it walks a contiguous address range, issues one `read_req` per word, absorbs the RAM's fixed read latency (1 + OUTPUT_REG cycles), and presents the returned words in address order on a valid/ready output stream. A small credit-controlled FIFO absorbs downstream backpressure without losing or duplicating words. The RAM write port is not touched by this block.

## Interface
- DATA_WIDTH, 10, width of a RAM word; must equal the attached `ram` DATA_WIDTH.
- ADDR_WIDTH, 12, RAM address width; must equal the attached `ram` ADDR_WIDTH.
- OUTPUT_REG, 1, must equal the attached `ram` OUTPUT_REG; read latency L = 1 + OUTPUT_REG.
- FIFO_DEPTH, 4, output buffer depth; power of two, ≥ L + 2 for one word/cycle throughput.

- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- start  in  1  one-cycle command strobe; accepted only in IDLE.
- base_addr  in  ADDR_WIDTH  first address, sampled with start.
- num_words  in  ADDR_WIDTH+1  word count 0..2^ADDR_WIDTH, sampled with start.
- busy  out  1  high in ISSUE and DRAIN.
- done  out  1  one-cycle completion pulse.
- read_req  out  1  to `ram` read_req.
- read_addr  out  ADDR_WIDTH  to `ram` read_addr.
- read_data  in  DATA_WIDTH  from `ram` read data.
- m_valid  out  1  output word valid.
- m_data  out  DATA_WIDTH  output word.
- m_ready  in  1  downstream accepts; transfer when m_valid && m_ready.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 with num_words≠0 → capture base_addr/num_words, go ISSUE; start=1 with num_words=0 → DONE; otherwise stay.
- ISSUE: read_req = (remaining≠0) && (fifo_count + inflight < FIFO_DEPTH); read_addr = current address. Each issue: address +1 modulo 2^ADDR_WIDTH (4095 → 0), remaining −1. When the last word issues → DRAIN.
- DRAIN: no reads; leave for DONE once inflight=0, FIFO empty, last word transferred.
- DONE: done=1 for exactly one cycle, → IDLE.
- read_req, read_addr derived from registers only; no combinational path from m_ready or start to any output.
- Latency tracking: L-deep valid shift register; bit L−1 set writes read_data into the FIFO that cycle. inflight = number of set bits.
- Credit uses registered fifo_count; a same-cycle pop is not credited, so FIFO overflow is impossible for any m_ready pattern.
- m_valid = FIFO non-empty; m_data = FIFO head; order strictly ascending (modulo) address.
- start outside IDLE (including DONE) is ignored; parameters of the running job unchanged.
- Reset asserted at any time: all state cleared, in-flight RAM reads discarded (their returning data is not written); next start after release behaves as from power-up.

## Timing
- Reset values: busy 0, done 0, read_req 0, read_addr 0, m_valid 0, m_data 0; state IDLE, FIFO empty, inflight 0.
- start sampled at edge of cycle s → busy high from s+1, first read_req in s+1.
- read_req high in cycle t → word on read_data in cycle t+L, written to FIFO at end of that cycle, m_valid high from t+L+1.
- Default (L=2): first m_valid in s+4.
- m_ready held high, FIFO_DEPTH ≥ L+2: one read_req per cycle, N words transferred in N consecutive cycles.
- done in cycle after final transfer; busy low in that cycle.
- Zero-length start at s: done=1 in s+1, busy never high, no read_req.

## Test plan
- Preload `ram` addresses 5..12 with 0x100+addr; start base 5, N=8, m_ready=1 → read_addr 5..12 in s+1..s+8, m_data 0x105..0x10C on consecutive cycles from s+4, done in s+12.
- Same job, m_ready=0 for cycles s+1..s+15 then 1 → read_req stops after 4 issues (count+inflight=4), no further reads until a pop; all 8 words delivered once, in order.
- Start base 4094, N=4 → read_addr 4094, 4095, 0, 1; data returned in that order.
- Start with N=0 → done pulses at s+1, busy/read_req/m_valid stay 0.
- Start N=8, drop reset at s+3 for 2 cycles → all outputs 0 immediately; after release no stale m_valid; fresh start base 20, N=2 returns only addresses 20, 21.
- Pulse start with base 100 while busy → ignored; running job completes unchanged, single done pulse.
